dmux4way_dispatcher: RTL and testbench
======================================

// Module: dmux4way_dispatcher
// PURPOSE
//   Sequencer for the 4-way demux datapath: accepts a valid/ready word stream and steers each
//   word to one of four consumer channels via a registered 2-bit select.
//   Target is either explicit (in_dest) or round-robin over ready consumers.
//   Sits between a single producer (e.g. CPU write port) and four memory-mapped sinks.
// PARAMETERS
//   DATA_W   16   width of data word (Hack word)
//   CNT_W    8    width of per-channel beat counters (only with DMUX_DISPATCH_CNT_EN)
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous reset, active low
//   mode_rr      in   1        1 = round-robin target choice, 0 = explicit in_dest
//   in_valid     in   1        producer has a word
//   in_ready     out  1        dispatcher accepts word this cycle
//   in_data      in   DATA_W   word
//   in_dest      in   2        explicit target channel (used when mode_rr=0)
//   out_valid    out  4        one-hot: held word valid on channel i
//   out_ready    in   4        consumer i accepts word
//   out_data     out  DATA_W   held word, shared by all channels
//   sel          out  2        registered select of channel currently/last targeted
//   busy         out  1        1 while a word is held
//   cnt_flat     out  4*CNT_W  per-channel delivered-beat counts, ch0 in LSBs (macro only)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, out_valid=0, out_data=0, sel=0, rr_ptr=0, busy=0,
//     counters=0. Deasserting rst_n takes effect on next clk edge; a held word is discarded.
//   - States: IDLE (no word held), HOLD (word held, out_valid[sel]=1, busy=1).
//   - in_ready = (state==IDLE) | out_ready[sel] & (state==HOLD)   (combinational; one-word
//     buffer with pass-through on handoff, full throughput 1 word/cycle).
//   - accept = in_valid & in_ready; deliver = (state==HOLD) & out_ready[sel].
//   - Transitions: IDLE--accept-->HOLD; HOLD--deliver & accept-->HOLD (new word);
//     HOLD--deliver & !accept-->IDLE; otherwise stay.
//   - On accept: out_data<=in_data, sel<=tgt, out_valid<=one-hot(tgt). Latency in->out = 1 cycle.
//   - tgt (mode_rr=0): in_dest.
//   - tgt (mode_rr=1): first i in order rr_ptr, rr_ptr+1, ... (mod 4) with out_ready[i]=1 in
//     accept cycle; if none ready, tgt=rr_ptr. rr_ptr<=tgt+1 (2-bit wrap 3->0) on accept only.
//   - rr_ptr unchanged in explicit mode; mode_rr sampled only at accept; changing it while HOLD
//     never alters the held word's sel.
//   - out_valid, out_data, sel stable while HOLD and !deliver (no retargeting of a held word).
//   - out_valid is all-zero or one-hot; never two channels valid.
//   - in_dest / in_data ignored when in_valid=0; out_ready of non-selected channels ignored.
// CONFIGURATION
//   DMUX_DISPATCH_CNT_EN defined: four CNT_W counters; counter[sel] increments on each deliver,
//     wraps 2^CNT_W-1 -> 0; reset to 0; driven on cnt_flat.
//   DMUX_DISPATCH_CNT_EN undefined: no counters; cnt_flat port is absent.
// TESTING
//   1 Reset: rst_n=0 mid-HOLD -> out_valid=4'b0000, busy=0, sel=0 same cycle (async).
//   2 Explicit: mode_rr=0, words 0x1111..0x4444 with in_dest=3,2,1,0, out_ready=4'hF ->
//     out_valid 1000,0100,0010,0001 one cycle after each accept, 1 word/cycle, in_ready=1 always.
//   3 Backpressure: in_dest=1, out_ready=4'b0000 for 5 cycles -> in_ready=0, out_data=0xBEEF and
//     out_valid=0010 held stable; out_ready[1]=1 -> delivered, next word accepted same cycle.
//   4 Round-robin: mode_rr=1, out_ready=4'hF, 6 words -> sel sequence 0,1,2,3,0,1.
//   5 RR skip: rr_ptr=1, out_ready=4'b1001 at accept -> sel=3, rr_ptr=0; none ready -> sel=rr_ptr.
//   6 Macro on: 300 delivers to ch2 with CNT_W=8 -> cnt ch2 = 44 (wrapped), others 0.

Source files
------------

// File: rtl/dmux4way_dispatcher.sv
// One-word valid/ready dispatcher that steers each word to one of four consumers, by explicit
// destination or round-robin. Optional beat counters are enabled with DMUX_DISPATCH_CNT_EN.
module dmux4way_dispatcher #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_rr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic              busy
`ifdef DMUX_DISPATCH_CNT_EN
  ,
  output logic [4*CNT_W-1:0] cnt_flat
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] rr_ptr;
  logic [1:0] tgt, tgt_rr, rr_idx;
  logic       accept, deliver;

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("dmux4way_dispatcher: DATA_W and CNT_W must be positive");
  end

  // A handoff frees the buffer in the same cycle, so a new word can follow back-to-back.
  assign deliver  = (state == HOLD) & out_ready[sel];
  assign in_ready = (state == IDLE) | deliver;
  assign accept   = in_valid & in_ready;
  assign busy     = (state == HOLD);

  // Scan from the furthest offset down so the nearest ready channel after rr_ptr wins.
  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    tgt_rr = rr_ptr;
    rr_idx = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = rr_ptr + 2'(k);
      if (out_ready[rr_idx]) tgt_rr = rr_idx;
    end
  end

  assign tgt = mode_rr ? tgt_rr : in_dest;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (deliver && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= '0;
      out_data  <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data  <= in_data;
        sel       <= tgt;
        out_valid <= 4'b0001 << tgt;
        if (mode_rr) rr_ptr <= tgt + 2'd1;
      end else if (deliver) begin
        out_valid <= '0;
      end
    end
  end

`ifdef DMUX_DISPATCH_CNT_EN
  logic [CNT_W-1:0] cnt [4];

  // NOTE: this small counter array is reset element by element; large storage arrays are normally left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (deliver) begin
      cnt[sel] <= cnt[sel] + 1'b1;
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < 4; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  // Without counters, deliveries are not tallied and cnt_flat does not exist.
`endif

endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Scoreboard bench for dmux4way_dispatcher: a monitor predicts handshakes and targets from a
// queue-based model; directed scenarios plus a randomized phase supply the stimulus.
module tb_dmux4way_dispatcher;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode_rr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        sel;
  logic              busy;
`ifdef DMUX_DISPATCH_CNT_EN
  logic [4*CNT_W-1:0] cnt_flat;
`endif

  dmux4way_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode_rr(mode_rr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .busy(busy)
`ifdef DMUX_DISPATCH_CNT_EN
    , .cnt_flat(cnt_flat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                ch;
  } item_t;

  item_t q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    ptr_m   = 0;
  logic [CNT_W-1:0] cnt_m [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle view of the handshakes that will happen at the coming rising edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        ptr_m = 0;
        for (int i = 0; i < 4; i++) cnt_m[i] = '0;
      end else begin
        logic exp_ready;
        logic [3:0] exp_valid;
        int tgt;
        exp_ready = (q.size() == 0) || out_ready[q[0].ch];
        exp_valid = (q.size() == 0) ? 4'b0000 : (4'b0001 << q[0].ch);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
`ifdef DMUX_DISPATCH_CNT_EN
        check("cnt_flat", cnt_flat, {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
`endif
        if (q.size() != 0) begin
          check("out_data", 32'(out_data), 32'(q[0].data));
          check("sel", 32'(sel), 32'(q[0].ch));
          if (out_ready[q[0].ch]) begin
            cnt_m[q[0].ch] = cnt_m[q[0].ch] + 1'b1;
            void'(q.pop_front());
          end
        end
        if (in_valid && exp_ready) begin
          if (mode_rr) begin
            tgt = ptr_m;
            for (int k = 3; k >= 0; k--)
              if (out_ready[(ptr_m + k) % 4]) tgt = (ptr_m + k) % 4;
            ptr_m = (tgt + 1) % 4;
          end else begin
            tgt = int'(in_dest);
          end
          q.push_back('{data: in_data, ch: tgt});
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; mode_rr = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; out_ready = '0;
    fork monitor(); join_none
    step();
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst sel", 32'(sel), 32'h0);
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset while a word is held
    in_valid = 1'b1; in_data = 16'hAAAA; in_dest = 2'd3; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    check("hold sel", 32'(sel), 32'h3);
    check("hold busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async sel", 32'(sel), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Explicit destinations at full throughput
    mode_rr = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h1111 * (i + 1)); in_dest = 2'(3 - i);
      #1 check("expl in_ready", 32'(in_ready), 32'h1);
      step();
      check("expl out_valid", 32'(out_valid), 32'(4'b0001 << (3 - i)));
    end
    in_valid = 1'b0;
    step();

    // Backpressure on channel 1
    in_valid = 1'b1; in_data = 16'hBEEF; in_dest = 2'd1; out_ready = 4'b0000;
    step();
    in_data = 16'hC0DE; in_dest = 2'd2;
    for (int i = 0; i < 5; i++) begin
      check("bp in_ready", 32'(in_ready), 32'h0);
      check("bp out_data", 32'(out_data), 32'hBEEF);
      check("bp out_valid", 32'(out_valid), 32'b0010);
      step();
    end
    out_ready = 4'b0010;
    #1 check("bp release in_ready", 32'(in_ready), 32'h1);
    step();
    check("bp next out_data", 32'(out_data), 32'hC0DE);
    check("bp next out_valid", 32'(out_valid), 32'b0100);
    in_valid = 1'b0; out_ready = 4'hF;
    step();

    // Round-robin with every consumer ready
    mode_rr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      step();
      check("rr sel", 32'(sel), 32'(i % 4));
    end
    // Three more words move the pointer from 2 to 1
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b1; out_ready = 4'b1001;
    step();
    check("rr skip sel", 32'(sel), 32'h3);
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; out_ready = 4'b0000;
    step();
    check("rr none sel", 32'(sel), 32'h0);
    check("rr none out_valid", 32'(out_valid), 32'b0001);
    in_valid = 1'b0; out_ready = 4'hF;
    step();

`ifdef DMUX_DISPATCH_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("cnt reset", cnt_flat, 32'h0);
    mode_rr = 1'b0; in_dest = 2'd2; out_ready = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("cnt wrap ch2", cnt_flat, 32'h002C_0000);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      mode_rr   = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_dest   = 2'($urandom_range(0, 3));
      out_ready = 4'($urandom);
      step();
    end

    in_valid = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    check("drain empty", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
